// File: rtl/prog_sequencer.sv
// prog_sequencer: multi-cycle control for the 9-bit processor. Owns the PC, runs the
// Start/Done harness handshake, stalls on data-memory loads and gates datapath writes.
`default_nettype none

module prog_sequencer #(
  parameter int PC_W       = 10,
  parameter int CYC_W      = 16,
  parameter int MEM_LAT    = 2,
  parameter int PROG0_BASE = 0,
  parameter int PROG1_BASE = 256,
  parameter int PROG2_BASE = 512
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       ProgSel,
  input  logic             Ack,
  input  logic             IsLoad,
  input  logic             BranchTaken,
  input  logic [PC_W-1:0]  BranchTarget,
  output logic [PC_W-1:0]  PC,
  output logic             InstrValid,
  output logic             Stall,
  output logic             RegWrGate,
  output logic             MemWrGate,
  output logic             Done,
  output logic [CYC_W-1:0] CycleCount
);

  localparam int              WAIT_W    = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'((MEM_LAT > 2) ? (MEM_LAT - 2) : 0);
  localparam bit              MULTI_LOAD = (MEM_LAT > 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INIT      = 3'd1,
    S_RUN       = 3'd2,
    S_LOAD_WAIT = 3'd3,
    S_HALT      = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [PC_W-1:0]   pc_nxt;
  logic [PC_W-1:0]   prog_base;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              restart;
  logic              cc_clr, cc_inc;
  logic              done_set;

  always_comb begin
    case (ProgSel)
      2'd1:    prog_base = PC_W'(PROG1_BASE);
      2'd2:    prog_base = PC_W'(PROG2_BASE);
      default: prog_base = PC_W'(PROG0_BASE);
    endcase
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = PC;
    wait_nxt   = wait_cnt;
    restart    = 1'b0;
    cc_clr     = 1'b0;
    cc_inc     = 1'b0;
    done_set   = 1'b0;
    InstrValid = 1'b0;
    Stall      = 1'b0;
    RegWrGate  = 1'b0;
    MemWrGate  = 1'b0;

    case (state)
      S_IDLE: begin
        restart = Start;
      end
      S_INIT: begin
        cc_clr = 1'b1;
        if (Start) restart = 1'b1;
        else       state_nxt = S_RUN;
      end
      S_RUN: begin
        InstrValid = 1'b1;
        cc_inc     = 1'b1;
        if (Start) begin
          restart = 1'b1;
        end else if (Ack) begin
          state_nxt = S_HALT;
          done_set  = 1'b1;
        end else if (IsLoad && MULTI_LOAD) begin
          state_nxt = S_LOAD_WAIT;
          Stall     = 1'b1;
          wait_nxt  = WAIT_INIT;
        end else begin
          RegWrGate = 1'b1;
          MemWrGate = 1'b1;
          // A load that also claims a branch is illegal; the load wins.
          pc_nxt    = (BranchTaken && !IsLoad) ? BranchTarget : PC + PC_W'(1);
        end
      end
      S_LOAD_WAIT: begin
        InstrValid = 1'b1;
        cc_inc     = 1'b1;
        if (Start) begin
          restart = 1'b1;
        end else if (wait_cnt != '0) begin
          Stall    = 1'b1;
          wait_nxt = wait_cnt - WAIT_W'(1);
        end else begin
          RegWrGate = 1'b1;
          pc_nxt    = PC + PC_W'(1);
          state_nxt = S_RUN;
        end
      end
      S_HALT: begin
        restart = Start;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    if (restart) begin
      state_nxt = S_INIT;
      pc_nxt    = prog_base;
      wait_nxt  = '0;
      cc_clr    = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= S_IDLE;
      PC         <= '0;
      wait_cnt   <= '0;
      Done       <= 1'b0;
      CycleCount <= '0;
    end else begin
      state    <= state_nxt;
      PC       <= pc_nxt;
      wait_cnt <= wait_nxt;
      if (restart || state == S_INIT) Done <= 1'b0;
      else if (done_set)             Done <= 1'b1;
      // Saturating cycle counter: holds at all-ones instead of wrapping.
      if (cc_clr)                                CycleCount <= '0;
      else if (cc_inc && CycleCount != '1)       CycleCount <= CycleCount + CYC_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_prog_sequencer.sv
// tb_prog_sequencer: three prog_sequencer instances (MEM_LAT 2/3/1) driven in lockstep
// and compared every cycle against a behavioural model of the sequencing rules.
`default_nettype none

module tb_prog_sequencer;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic [1:0] ProgSel = 2'd0;
  logic       Ack = 1'b0;
  logic       IsLoad = 1'b0;
  logic       BranchTaken = 1'b0;
  logic [9:0] BranchTarget = 10'd0;

  always #5 Clk = ~Clk;

  logic [9:0]  pc_o [3];
  logic        iv_o [3];
  logic        st_o [3];
  logic        rw_o [3];
  logic        mw_o [3];
  logic        dn_o [3];
  logic [15:0] cc0;
  logic [3:0]  cc1;
  logic [4:0]  cc2;

  prog_sequencer u0 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel), .Ack(Ack), .IsLoad(IsLoad),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget), .PC(pc_o[0]), .InstrValid(iv_o[0]),
    .Stall(st_o[0]), .RegWrGate(rw_o[0]), .MemWrGate(mw_o[0]), .Done(dn_o[0]), .CycleCount(cc0));

  prog_sequencer #(.MEM_LAT(3), .CYC_W(4)) u1 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel), .Ack(Ack), .IsLoad(IsLoad),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget), .PC(pc_o[1]), .InstrValid(iv_o[1]),
    .Stall(st_o[1]), .RegWrGate(rw_o[1]), .MemWrGate(mw_o[1]), .Done(dn_o[1]), .CycleCount(cc1));

  prog_sequencer #(.MEM_LAT(1), .CYC_W(5)) u2 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel), .Ack(Ack), .IsLoad(IsLoad),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget), .PC(pc_o[2]), .InstrValid(iv_o[2]),
    .Stall(st_o[2]), .RegWrGate(rw_o[2]), .MemWrGate(mw_o[2]), .Done(dn_o[2]), .CycleCount(cc2));

  // Model: mode plus the number of load cycles still owed by the current instruction.
  localparam int M_IDLE = 0, M_INIT = 1, M_RUN = 2, M_HALT = 3;
  int lat   [3] = '{2, 3, 1};
  int ccmax [3] = '{65535, 15, 31};
  int m_mode [3];
  int m_pc   [3];
  int m_cc   [3];
  int m_done [3];
  int m_left [3];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int base_of(input logic [1:0] sel);
    return (sel == 2'd1) ? 256 : (sel == 2'd2) ? 512 : 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_mode[i] = M_IDLE; m_pc[i] = 0; m_cc[i] = 0; m_done[i] = 0; m_left[i] = 0;
    end
  endtask

  function automatic logic [31:0] cc_of(input int i);
    return (i == 0) ? {16'd0, cc0} : (i == 1) ? {28'd0, cc1} : {27'd0, cc2};
  endfunction

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      int e_iv, e_st, e_rw, e_mw;
      e_iv = 0; e_st = 0; e_rw = 0; e_mw = 0;
      if (m_mode[i] == M_RUN) begin
        e_iv = 1;
        if (Start) begin
        end else if (m_left[i] > 0) begin
          if (m_left[i] > 1) e_st = 1;
          else               e_rw = 1;
        end else if (Ack) begin
        end else if (IsLoad && lat[i] > 1) begin
          e_st = 1;
        end else begin
          e_rw = 1; e_mw = 1;
        end
      end
      chk($sformatf("pc%0d", i),    {22'd0, pc_o[i]}, m_pc[i]);
      chk($sformatf("valid%0d", i), {31'd0, iv_o[i]}, e_iv);
      chk($sformatf("stall%0d", i), {31'd0, st_o[i]}, e_st);
      chk($sformatf("regwr%0d", i), {31'd0, rw_o[i]}, e_rw);
      chk($sformatf("memwr%0d", i), {31'd0, mw_o[i]}, e_mw);
      chk($sformatf("done%0d", i),  {31'd0, dn_o[i]}, m_done[i]);
      chk($sformatf("cycles%0d", i), cc_of(i), m_cc[i]);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      if (Start) begin
        m_mode[i] = M_INIT; m_pc[i] = base_of(ProgSel); m_cc[i] = 0; m_done[i] = 0; m_left[i] = 0;
      end else if (m_mode[i] == M_INIT) begin
        m_mode[i] = M_RUN;
      end else if (m_mode[i] == M_RUN) begin
        if (m_cc[i] < ccmax[i]) m_cc[i]++;
        if (m_left[i] > 0) begin
          m_left[i]--;
          if (m_left[i] == 0) m_pc[i] = (m_pc[i] + 1) % 1024;
        end else if (Ack) begin
          m_mode[i] = M_HALT; m_done[i] = 1;
        end else if (IsLoad && lat[i] > 1) begin
          m_left[i] = lat[i] - 1;
        end else if (BranchTaken && !IsLoad) begin
          m_pc[i] = BranchTarget;
        end else begin
          m_pc[i] = (m_pc[i] + 1) % 1024;
        end
      end
    end
  endtask

  task automatic step(input logic s, input logic [1:0] sel, input logic a, input logic l,
                      input logic b, input logic [9:0] t);
    Start = s; ProgSel = sel; Ack = a; IsLoad = l; BranchTaken = b; BranchTarget = t;
    #4;
    check_all();
    model_edge();
    @(posedge Clk);
    #1;
  endtask

  task automatic restart(input logic [1:0] sel);
    step(1'b1, sel, 1'b0, 1'b0, 1'b0, 10'd0);
    step(1'b0, sel, 1'b0, 1'b0, 1'b0, 10'd0);
  endtask

  task automatic run_plain(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 10'd0);
  endtask

  task automatic async_reset();
    Reset = 1'b1;
    #1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_pc%0d", i),    {22'd0, pc_o[i]}, 0);
      chk($sformatf("rst_done%0d", i),  {31'd0, dn_o[i]}, 0);
      chk($sformatf("rst_stall%0d", i), {31'd0, st_o[i]}, 0);
      chk($sformatf("rst_gates%0d", i), {30'd0, rw_o[i], mw_o[i]}, 0);
    end
    @(posedge Clk);
    #1;
    Reset = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    check_all();
    Reset = 1'b0;

    // Reset asserted while u0/u1 sit in the load wait
    restart(2'd0);
    run_plain(2);
    step(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 10'd0);
    async_reset();
    step(1'b0, 2'd2, 1'b1, 1'b1, 1'b1, 10'd77);
    step(1'b0, 2'd1, 1'b0, 1'b0, 0, 10'd0);

    // Program 1, Start held three cycles, halt on the fifth instruction
    for (int k = 0; k < 3; k++) step(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 10'd0);
    step(1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 10'd0);
    for (int k = 0; k < 5; k++) step(1'b0, 2'd0, (k == 4), 1'b0, 1'b0, 10'd0);
    chk("halt_done", {31'd0, dn_o[0]}, 1);
    chk("halt_cycles", {16'd0, cc0}, 5);
    chk("halt_pc", {22'd0, pc_o[0]}, 260);
    run_plain(2);

    // Load at PC=10, then branch to the top of memory and wrap
    restart(2'd0);
    run_plain(10);
    step(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 10'd0);
    run_plain(3);
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 10'h3FF);
    run_plain(3);

    // Abort from program 1 at PC=300 into program 0
    restart(2'd1);
    run_plain(44);
    chk("abort_pc", {22'd0, pc_o[0]}, 300);
    step(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 10'd0);
    step(1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 10'd0);
    run_plain(3);

    // Long program: the narrow counters saturate
    restart(2'd2);
    run_plain(20);
    step(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 10'd0);
    chk("sat_cycles", {28'd0, cc1}, 15);
    chk("sat_done", {31'd0, dn_o[1]}, 1);
    run_plain(2);

    for (int n = 0; n < 3000; n++) begin
      logic s, a, l, b;
      logic [9:0] t;
      if ($urandom_range(0, 399) == 0) async_reset();
      s = ($urandom_range(0, 39) == 0);
      a = ($urandom_range(0, 24) == 0);
      l = ($urandom_range(0, 7) == 0);
      b = !l && ($urandom_range(0, 5) == 0);
      t = ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom);
      step(s, 2'($urandom), a, l, b, t);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
